// File: rtl/sand_fetch.sv
// sand_fetch: Avalon-MM pipelined read master that streams one frame of words, in address order.
// Optional build macro SAND_FETCH_EOL_EN adds the pix_eol row marker and its column counter.
module sand_fetch #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int FRAME_WORDS = 76800,
  parameter int MAX_PEND    = 8,
  parameter int ROW_WORDS   = 320
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last
`ifdef SAND_FETCH_EOL_EN
  ,
  output logic              pix_eol
`endif
);

  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int AW = $clog2(MAX_PEND);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);
  localparam logic [PW:0]   PEND_MAX = (PW + 1)'(MAX_PEND);
  localparam logic [PW-1:0] FIFO_FULL = PW'(MAX_PEND);

  if (MAX_PEND < 2 || (MAX_PEND & (MAX_PEND - 1)) != 0 || FRAME_WORDS < 1 || ROW_WORDS < 1)
  begin : g_bad_params
    $error("sand_fetch: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;
  state_t state;

  logic [ADDR_W-1:0] base_q;
  logic [CW-1:0]     issued, popped, issued_n;
  logic [PW-1:0]     inflight, count, inflight_n, count_n;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_mem [MAX_PEND];
  logic              accept, push, pop, credit_ok, full;

  // Handshakes: a read transfers on mem_read & !mem_waitrequest (request held stable while stalled);
  // a stream word transfers on pix_valid & pix_ready, and the stream outputs hold while not accepted.
  always_comb begin
    accept     = mem_read && !mem_waitrequest;
    push       = mem_readdatavalid && (state != S_IDLE);
    pop        = pix_valid && pix_ready;
    full       = (count == FIFO_FULL);
    issued_n   = issued + CW'(accept);
    inflight_n = inflight + PW'(accept) - PW'(push);
    count_n    = count + PW'(push) - PW'(pop);
    credit_ok  = ({1'b0, inflight_n} + {1'b0, count_n}) < PEND_MAX;
  end

  assign pix_valid = (count != '0);
  assign pix_data  = fifo_mem[rd_ptr];
  assign pix_last  = pix_valid && (popped == LAST_IDX);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= mem_readdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      base_q      <= '0;
      issued      <= '0;
      popped      <= '0;
      inflight    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= inflight_n;
      count    <= count_n;
      if (done) busy <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        popped <= popped + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_FETCH;
            busy        <= 1'b1;
            base_q      <= base_addr;
            issued      <= '0;
            popped      <= '0;
            mem_read    <= 1'b1;
            mem_address <= base_addr;
          end
        end
        S_FETCH: begin
          if (accept) begin
            issued <= issued_n;
            if (issued == LAST_IDX) begin
              state    <= S_DRAIN;
              mem_read <= 1'b0;
            end else begin
              // Next-state occupancy already counts this accept, so a new request never overcommits.
              mem_read    <= credit_ok;
              mem_address <= base_q + ADDR_W'(issued_n);
            end
          end else if (!mem_read) begin
            mem_read <= credit_ok;
          end
        end
        S_DRAIN: begin
          if (pop && (popped == LAST_IDX)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SAND_FETCH_EOL_EN
  localparam int COLW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam logic [COLW-1:0] ROW_LAST = COLW'(ROW_WORDS - 1);
  logic [COLW-1:0] col;

  always_ff @(posedge clock) begin
    if (reset || (state == S_IDLE && start)) col <= '0;
    else if (pop) col <= (col == ROW_LAST) ? '0 : col + 1'b1;
  end

  assign pix_eol = pix_valid && (col == ROW_LAST);
`endif

  a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full && !pop));

endmodule

// File: tb/tb_sand_fetch.sv
// Directed bench for sand_fetch: Avalon slave model with 1-cycle read latency, scoreboard queues for
// addresses and stream words, immediate-assertion checks and a single summary line.
module tb_sand_fetch;

  localparam int FW = 12;
  localparam int MP = 8;
  localparam int RW = 4;

  logic        clock;
  logic        reset;
  logic        start;
  logic [23:0] base_addr;
  logic        busy, done;
  logic [23:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic        mem_readdatavalid = 1'b0;
  logic [15:0] mem_readdata = 16'h0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;
`ifdef SAND_FETCH_EOL_EN
  logic        pix_eol;
`endif

  sand_fetch #(
    .ADDR_W(24), .DATA_W(16), .FRAME_WORDS(FW), .MAX_PEND(MP), .ROW_WORDS(RW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done),
    .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid), .mem_readdata(mem_readdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last)
`ifdef SAND_FETCH_EOL_EN
    , .pix_eol(pix_eol)
`endif
  );

  // ---------------- clock / reset / counters ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_acc = 0, pop_idx = 0, done_cnt = 0, acc_first = -1, acc_last = -1;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [23:0] exp_addr_q[$];

  function automatic logic [15:0] word_of(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model: 1-cycle read latency ----------------
  logic        sl_acc = 1'b0;
  logic [23:0] sl_addr = 24'h0;

  always @(negedge clock) begin
    sl_acc  = !reset && mem_read && !mem_waitrequest;
    sl_addr = mem_address;
  end

  always @(posedge clock) begin
    #1;
    mem_readdatavalid = sl_acc;
    mem_readdata      = sl_acc ? word_of(sl_addr) : 16'h0;
  end

  // ---------------- monitor ----------------
  logic        hold_prev = 1'b0;
  logic [23:0] hold_addr = 24'h0;

  always @(negedge clock) begin
    if (!reset) begin
      if (hold_prev) begin
        chk("req_hold_read", mem_read, 1);
        chk("req_hold_addr", mem_address, hold_addr);
      end
      hold_prev = mem_read && mem_waitrequest;
      hold_addr = mem_address;
      if (mem_read && !mem_waitrequest) begin
        if (acc_first < 0) acc_first = cyc;
        acc_last = cyc;
        frame_acc++;
        chk("read_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) chk("read_addr", mem_address, exp_addr_q.pop_front());
      end
      if (pix_valid && pix_ready) begin
        chk("pop_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("pix_data", pix_data, exp_q.pop_front());
        chk("pix_last", pix_last, pop_idx == FW - 1);
`ifdef SAND_FETCH_EOL_EN
        chk("pix_eol", pix_eol, (pop_idx % RW) == RW - 1);
`endif
        pop_idx++;
      end
      if (done) done_cnt++;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [23:0] b);
    @(posedge clock); #1;
    for (int i = 0; i < FW; i++) begin
      exp_addr_q.push_back(b + 24'(i));
      exp_q.push_back(word_of(b + 24'(i)));
    end
    frame_acc = 0; pop_idx = 0; done_cnt = 0; acc_first = -1; acc_last = -1;
    start = 1'b1;
    base_addr = b;
    @(posedge clock); #1;
    start = 1'b0;
    base_addr = 24'h0;
    chk("start_mem_read", mem_read, 1);
    chk("start_addr", mem_address, b);
    chk("start_busy", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clock);
    while (done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("done_seen", done, 1);
    chk("done_busy_high", busy, 1);
    @(negedge clock);
    chk("done_one_pulse", done, 0);
    chk("busy_dropped", busy, 0);
    chk("done_count", done_cnt, 1);
    chk("words_all_popped", exp_q.size(), 0);
    chk("reads_all_issued", exp_addr_q.size(), 0);
    chk("frame_reads", frame_acc, FW);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = 24'h0;
    mem_waitrequest = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_last", pix_last, 0);
`ifdef SAND_FETCH_EOL_EN
    chk("rst_pix_eol", pix_eol, 0);
`endif

    // T1: plain frame, reads back-to-back
    start_frame(24'h000100);
    wait_done(200);
    chk("t1_back_to_back", acc_last - acc_first, FW - 1);

    // T2: 3-cycle stall on the second read
    start_frame(24'h002000);
    @(posedge clock); #1;
    mem_waitrequest = 1'b1;
    repeat (3) begin
      chk("t2_stall_read", mem_read, 1);
      chk("t2_stall_addr", mem_address, 24'h002001);
      @(posedge clock); #1;
    end
    mem_waitrequest = 1'b0;
    wait_done(200);

    // T3: consumer stalled, credit caps reads at MAX_PEND
    pix_ready = 1'b0;
    start_frame(24'h003000);
    repeat (30) @(negedge clock);
    chk("t3_reads_capped", frame_acc, MP);
    chk("t3_read_low", mem_read, 0);
    chk("t3_valid", pix_valid, 1);
    chk("t3_head_data", pix_data, exp_q[0]);
    chk("t3_head_not_last", pix_last, 0);
    @(negedge clock);
    chk("t3_head_hold", pix_data, exp_q[0]);
    @(posedge clock); #1;
    pix_ready = 1'b1;
    wait_done(300);

    // T4: address wrap, plus a start pulse while busy that must be ignored
    start_frame(24'hFFFFFE);
    @(posedge clock); #1;
    start = 1'b1;
    base_addr = 24'h000555;
    @(posedge clock); #1;
    start = 1'b0;
    base_addr = 24'h0;
    chk("t4_busy_kept", busy, 1);
    wait_done(200);

    // T5: reset mid-frame, then a fresh fetch from word 0
    start_frame(24'h004000);
    begin
      int n;
      n = 0;
      while (pop_idx < 2 && n < 100) begin
        @(negedge clock);
        n++;
      end
    end
    chk("t5_two_popped", pop_idx >= 2, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("t5_mem_read", mem_read, 0);
    chk("t5_busy", busy, 0);
    chk("t5_pix_valid", pix_valid, 0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (3) begin
      @(negedge clock);
      chk("t5_no_reads", mem_read, 0);
    end
    start_frame(24'h004000);
    wait_done(200);

    repeat (5) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
